// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon sponge controller.
// Round constants are indexed 12-R .. 11 so reduced-round variants use the tail of the table.
package ascon_pkg;

    localparam int ROUND_IDX_W = 4;
    localparam int MAX_ROUNDS  = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT_P,
        ABSORB,
        ABS_P,
        FIN_P,
        SQUEEZE,
        SQ_P
    } ascon_ctrl_state_t;

    function automatic logic [ROUND_IDX_W-1:0] round_const_idx(
        input logic [ROUND_IDX_W-1:0] rounds,
        input logic [ROUND_IDX_W-1:0] rcnt
    );
        return ROUND_IDX_W'(MAX_ROUNDS) - rounds + rcnt;
    endfunction

endpackage

// File: rtl/ascon_round_sched.sv
// Round scheduler: counts rounds of the active permutation burst and emits the
// round-constant index plus a flag on the final round of the burst.
module ascon_round_sched
    import ascon_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [ROUND_IDX_W-1:0] rounds,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   last_round
);

    logic [ROUND_IDX_W-1:0] rcnt;

    assign last_round = en && (rcnt == rounds - 1'b1);
    assign round_idx  = en ? round_const_idx(rounds, rcnt) : '0;

    // Counter self-clears at the end of each burst so the next burst starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rcnt <= '0;
        else if (last_round)
            rcnt <= '0;
        else if (en)
            rcnt <= rcnt + 1'b1;
    end

endmodule

// File: rtl/ascon_sponge_ctrl.sv
// Ascon-Hash/XOF sponge controller: sequences IV load, absorb, permutation bursts
// and squeeze with valid/ready handshakes on both the message and output sides.
module ascon_sponge_ctrl
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A   = 12,
    parameter int ROUNDS_B   = 12,
    parameter int OUT_BLOCKS = 4,
    parameter int BLK_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   xof_en,
    input  logic [BLK_W-1:0]       xof_blocks,
    input  logic                   msg_valid,
    input  logic                   msg_last,
    output logic                   msg_ready,
    output logic                   absorb_en,
    output logic                   init_load,
    output logic                   round_en,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ROUND_IDX_W-1:0] RA = ROUND_IDX_W'(ROUNDS_A);
    localparam logic [ROUND_IDX_W-1:0] RB = ROUND_IDX_W'(ROUNDS_B);

    ascon_ctrl_state_t      state;
    logic [BLK_W-1:0]       blocks_tgt;
    logic [BLK_W-1:0]       ocnt;
    logic [ROUND_IDX_W-1:0] rounds_sel;
    logic                   last_round;

    assign msg_ready  = (state == ABSORB);
    assign absorb_en  = msg_ready && msg_valid;
    assign init_load  = (state == LOAD);
    assign round_en   = (state == INIT_P) || (state == ABS_P) ||
                        (state == FIN_P)  || (state == SQ_P);
    assign out_valid  = (state == SQUEEZE);
    assign out_last   = out_valid && (ocnt == blocks_tgt - 1'b1);
    assign busy       = (state != IDLE);

    // Init and final permutations are the full-strength ones; the rest use ROUNDS_B.
    assign rounds_sel = ((state == INIT_P) || (state == FIN_P)) ? RA : RB;

    ascon_round_sched u_sched (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (round_en),
        .rounds     (rounds_sel),
        .round_idx  (round_idx),
        .last_round (last_round)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            blocks_tgt <= '0;
            ocnt       <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // A zero XOF length still produces one block.
                    blocks_tgt <= xof_en ? ((xof_blocks == '0) ? BLK_W'(1) : xof_blocks)
                                         : BLK_W'(OUT_BLOCKS);
                    state      <= LOAD;
                end
                LOAD:    state <= INIT_P;
                INIT_P:  if (last_round) state <= ABSORB;
                ABSORB:  if (msg_valid) state <= msg_last ? FIN_P : ABS_P;
                ABS_P:   if (last_round) state <= ABSORB;
                FIN_P:   if (last_round) state <= SQUEEZE;
                SQ_P:    if (last_round) state <= SQUEEZE;
                SQUEEZE: if (out_ready) begin
                    if (out_last) begin
                        state <= IDLE;
                        ocnt  <= '0;
                        done  <= 1'b1;
                    end else begin
                        ocnt  <= ocnt + 1'b1;
                        state <= SQ_P;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_sponge_ctrl.sv
// Trace-based bench: each transaction is expanded into a per-cycle table of
// stimulus and expected outputs derived from the phase sequence of the sponge.
module tb_ascon_sponge_ctrl;

    localparam int RA = 12;
    localparam int RB = 8;
    localparam int OB = 4;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, xof_en, msg_valid, msg_last, out_ready;
    logic [BW-1:0] xof_blocks;
    logic          msg_ready, absorb_en, init_load, round_en, out_valid, out_last, busy, done;
    logic [3:0]    round_idx;
    logic [11:0]   obs;

    always #5 clk = ~clk;

    ascon_sponge_ctrl #(
        .ROUNDS_A(RA), .ROUNDS_B(RB), .OUT_BLOCKS(OB), .BLK_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .xof_en(xof_en), .xof_blocks(xof_blocks),
        .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .absorb_en(absorb_en), .init_load(init_load), .round_en(round_en),
        .round_idx(round_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    assign obs = {msg_ready, absorb_en, init_load, round_en, round_idx,
                  out_valid, out_last, busy, done};

    typedef struct packed {
        logic          start;
        logic          xof_en;
        logic [BW-1:0] xof_blocks;
        logic          msg_valid;
        logic          msg_last;
        logic          out_ready;
        logic [11:0]   exp;
    } step_t;

    step_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    fin_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [11:0] ev(bit mr, bit ab, bit il, bit re, int idx,
                                       bit ov, bit ol, bit bz, bit dn);
        return {mr, ab, il, re, 4'(idx), ov, ol, bz, dn};
    endfunction

    task automatic add(input logic st, input logic xe, input logic [BW-1:0] xb,
                       input logic mv, input logic ml, input logic ordy, input logic [11:0] e);
        step_t s;
        s.start = st; s.xof_en = xe; s.xof_blocks = xb;
        s.msg_valid = mv; s.msg_last = ml; s.out_ready = ordy; s.exp = e;
        q.push_back(s);
    endtask

    // Busy cycle: start and config are random noise that must be ignored.
    task automatic addn(input logic mv, input logic ml, input logic ordy, input logic [11:0] e);
        add(($urandom_range(0, 3) == 0), rb(), BW'($urandom), mv, ml, ordy, e);
    endtask

    task automatic rounds(input int r);
        for (int i = 0; i < r; i++)
            addn(rb(), rb(), rb(), ev(0, 0, 0, 1, 12 - r + i, 0, 0, 1, 0));
    endtask

    task automatic build(input bit xe, input logic [BW-1:0] xb, input int nb,
                         input int max_gap, input int max_stall);
        int nt;
        nt = xe ? ((xb == 0) ? 1 : int'(xb)) : OB;
        add(1'b1, xe, xb, rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        addn(rb(), rb(), rb(), ev(0, 0, 1, 0, 0, 0, 0, 1, 0));
        rounds(RA);
        for (int k = 0; k < nb; k++) begin
            int g;
            g = $urandom_range(0, max_gap);
            for (int i = 0; i < g; i++)
                addn(1'b0, rb(), rb(), ev(1, 0, 0, 0, 0, 0, 0, 1, 0));
            addn(1'b1, (k == nb - 1), rb(), ev(1, 1, 0, 0, 0, 0, 0, 1, 0));
            if (k == nb - 1) fin_idx = q.size();
            rounds((k == nb - 1) ? RA : RB);
        end
        for (int j = 0; j < nt; j++) begin
            int s;
            bit lst;
            lst = (j == nt - 1);
            s = $urandom_range(0, max_stall);
            for (int i = 0; i < s; i++)
                addn(rb(), rb(), 1'b0, ev(0, 0, 0, 0, 0, 1, lst, 1, 0));
            addn(rb(), rb(), 1'b1, ev(0, 0, 0, 0, 0, 1, lst, 1, 0));
            if (!lst) rounds(RB);
        end
        add(1'b0, rb(), BW'($urandom), rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    // Plays the queued trace; stops before step 'cut' when cut >= 0.
    task automatic run(input string name, input int cut);
        int n = 0;
        while (q.size() > 0) begin
            step_t s;
            if (n == cut) begin
                q.delete();
                break;
            end
            s = q.pop_front();
            start = s.start; xof_en = s.xof_en; xof_blocks = s.xof_blocks;
            msg_valid = s.msg_valid; msg_last = s.msg_last; out_ready = s.out_ready;
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, n), 32'(obs), 32'(s.exp));
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0; msg_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; xof_en = 1'b0; xof_blocks = '0;
        msg_valid = 1'b0; msg_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 32'(obs), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Hash, single block, no stalls: first out_valid lands 27 cycles after start.
        build(1'b0, '0, 1, 0, 0);
        run("hash1", -1);

        build(1'b0, '0, 3, 3, 0);
        run("hash3", -1);

        build(1'b1, 8'd0, 1, 1, 2);
        run("xof0", -1);

        build(1'b1, 8'd7, 2, 1, 3);
        run("xof7", -1);

        // Reset asserted for one cycle in the middle of the final permutation.
        build(1'b0, '0, 1, 0, 0);
        run("prerst", fin_idx + 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        build(1'b0, '0, 1, 1, 1);
        run("postrst", -1);

        for (int t = 0; t < 8; t++) begin
            build(rb(), BW'($urandom_range(0, 9)), $urandom_range(1, 4), 2, 3);
            run($sformatf("rnd%0d", t), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
